prime_pair_search: RTL and testbench
====================================

# prime_pair_search

Sequencing controller that drives the shared prime-checker datapath to find the two RSA primes. From a 32-bit seed it walks odd candidates upward and issues each one to the prime checker over its ready/done handshake. It records the first two primes found as `prime1` < `prime2` and hands them to key generation. It sits between the I/O/control layer (seed, start) and the prime checker instance.

## Interface
Parameters:
- `MAX_TRIES`, default 1024: maximum candidates tested per search.
- `TIMEOUT`, default 4096: maximum cycles to wait for `pc_done` on one candidate.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a search; honoured only in IDLE.
- `seed` in 32: search start point; sampled when `start` is accepted.
- `pc_candidate` out 32: candidate driven to the prime checker.
- `pc_ready` out 1: one-cycle issue strobe to the prime checker.
- `pc_isprime` in 1: checker verdict; valid only while `pc_done`=1.
- `pc_done` in 1: checker completion strobe, one cycle.
- `prime1` out 32: first prime found.
- `prime2` out 32: second prime found.
- `busy` out 1: high from start accept until DONE/FAIL.
- `done` out 1: one-cycle success pulse.
- `fail` out 1: one-cycle failure pulse.
- `status` out 2: result code. 0 = ok, 1 = tries exhausted, 2 = candidate overflow, 3 = checker timeout.

## Operation
States: IDLE, ISSUE, WAIT, EVAL, DONE, FAIL.

- **IDLE**
  - On `start`: candidate = `seed | 1`; if that value is < 3, candidate = 3.
  - Clear the found count, try count, `prime1`, `prime2` and `status`; go to ISSUE.
  - `pc_done` arriving in IDLE is ignored.
- **ISSUE**: assert `pc_ready` for one cycle; try count += 1; timeout counter = 0; go to WAIT.
- **WAIT**
  - `pc_candidate` is held stable.
  - On `pc_done`: latch `pc_isprime` and go to EVAL.
  - If the timeout counter reaches `TIMEOUT-1` without `pc_done`: status = 3, go to FAIL.
- **EVAL**
  - If prime and found = 0: `prime1` = candidate, found = 1.
  - If prime and found = 1: `prime2` = candidate; go to DONE.
  - Otherwise, in this order:
    - If candidate = 0xFFFFFFFF or 0xFFFFFFFE: status = 2, go to FAIL. The +2 step would wrap.
    - Else if try count = `MAX_TRIES`: status = 1, go to FAIL.
    - Else candidate += 2, go to ISSUE.
- **DONE**: `done` = 1 for one cycle, then IDLE.
- **FAIL**: `fail` = 1 for one cycle, then IDLE. `prime1` keeps any partial result.

Rules:
- `prime1`, `prime2` and `status` hold their values until the next accepted `start`.
- Candidates strictly increase, so `prime2` > `prime1` is guaranteed. No equality check is needed.
- `start` while `busy` is ignored.
- Arithmetic is unsigned 32-bit. The try count is 16 bits or more (clog2(`MAX_TRIES`)+1).

## Timing
- Reset value of every output is 0. State returns to IDLE and all counters clear.
- Reset asserted mid-search aborts it. No `done`/`fail` pulse is produced, and a late `pc_done` is ignored.
- `start` accepted at edge N: `busy` goes high at N+1 and `pc_ready` is asserted during cycle N+1 (ISSUE).
- Per-candidate cost: 1 (ISSUE) + checker latency L (WAIT, counted from the ISSUE edge) + 1 (EVAL) cycles.
- `done`/`fail` assert in the cycle after the deciding EVAL. `busy` drops in that same cycle.
- `pc_done` in the same cycle as `pc_ready` is not possible; the checker needs at least 1 cycle.
- If `pc_done` coincides with the timeout terminal count, `pc_done` wins.

## Structure
- Shared package `rsa_pkg` holds:
  - the `search_state_t` enum;
  - the `search_status_t` enum with values OK, TRIES, OVERFLOW, TIMEOUT;
  - the constants `CAND_W` = 32 and `PRIME_MIN` = 3.
- One sub-module, `prime_candidate_gen`, owns:
  - the candidate register;
  - the seed normalisation (force odd, minimum 3);
  - the +2 step;
  - the `last` flag (candidate ≥ 0xFFFFFFFE).
- The FSM, counters and result registers stay in `prime_pair_search`.

## Test plan
Bench uses a behavioural checker model with L = 5 unless stated.

- Seed 40, `start` → candidates 41, 43 issued; `prime1`=41, `prime2`=43, `status`=0, one `done` pulse.
- Seed 0 → first candidate 3; `prime1`=3, `prime2`=5. Seed 24 → candidates 25, 27, 29, 31; result 29, 31; 4 `pc_ready` pulses.
- `MAX_TRIES`=4, seed 90 → candidates 91, 93, 95, 97; `prime1`=97, then `fail` with `status`=1 and no `prime2`.
- Seed 0xFFFFFFF1 → `prime1`=0xFFFFFFFB (4294967291); 0xFFFFFFFD and 0xFFFFFFFF tested composite; `fail` with `status`=2.
- Checker model never asserts `pc_done`, `TIMEOUT`=16 → `fail` with `status`=3 exactly 16 cycles after `pc_ready`. A `start` pulse during WAIT is ignored.
- `reset` pulsed during WAIT, then a stale `pc_done` → all outputs 0, state IDLE, no `done`/`fail`. A fresh start with seed 40 then yields 41, 43.

Source files
------------

// File: rtl/rsa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_pkg                                                              |
// | Shared types and constants for the RSA prime search path.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rsa_pkg;

  localparam int              CAND_W    = 32;
  localparam logic [CAND_W-1:0] PRIME_MIN = 32'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } search_state_t;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_TRIES    = 2'd1,
    STATUS_OVERFLOW = 2'd2,
    STATUS_TIMEOUT  = 2'd3
  } search_status_t;

endpackage
`default_nettype wire

// File: rtl/prime_pair_search_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prime_pair_search_if                                                 |
// | Issue/verdict handshake between the search controller and checker.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface prime_pair_search_if;
  import rsa_pkg::*;

  logic [CAND_W-1:0] pc_candidate;
  logic              pc_ready;
  logic              pc_isprime;
  logic              pc_done;

  modport master (
    output pc_candidate,
    output pc_ready,
    input  pc_isprime,
    input  pc_done
  );

  modport slave (
    input  pc_candidate,
    input  pc_ready,
    output pc_isprime,
    output pc_done
  );

endinterface
`default_nettype wire

// File: rtl/prime_candidate_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prime_candidate_gen                                                  |
// | Candidate register: odd/minimum seed load, +2 step, wrap-guard flag. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prime_candidate_gen
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [CAND_W-1:0] seed_i,
  input  logic              step_i,
  output logic [CAND_W-1:0] cand_o,
  output logic              last_o
);

  logic [CAND_W-1:0] cand_q;
  logic [CAND_W-1:0] cand_d;
  logic [CAND_W-1:0] seed_odd;

  always_comb begin
    seed_odd = seed_i | 32'd1;
    cand_d   = cand_q;
    if (load_i) begin
      cand_d = (seed_odd < PRIME_MIN) ? PRIME_MIN : seed_odd;
    end else if (step_i) begin
      cand_d = cand_q + 32'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
    end else begin
      cand_q <= cand_d;
    end
  end

  assign cand_o = cand_q;
  // Any further +2 from here would wrap past 2^32.
  assign last_o = (cand_q >= 32'hFFFF_FFFE);

endmodule
`default_nettype wire

// File: rtl/prime_pair_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prime_pair_search                                                    |
// | Walks odd candidates through the prime checker, keeps first two.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prime_pair_search
  import rsa_pkg::*;
#(
  parameter int MAX_TRIES = 1024,
  parameter int TIMEOUT   = 4096
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CAND_W-1:0]   seed,
  prime_pair_search_if.master pc,
  output logic [CAND_W-1:0]   prime1,
  output logic [CAND_W-1:0]   prime2,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [1:0]          status
);

  localparam int TRY_W = (($clog2(MAX_TRIES) + 1) > 16) ? ($clog2(MAX_TRIES) + 1) : 16;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  // Counter would reach TIMEOUT-1 on this edge; needs TIMEOUT >= 2.
  localparam logic [TMO_W-1:0] TMO_TERM  = TMO_W'(TIMEOUT - 2);

  search_state_t     state_q, state_d;
  search_status_t    status_q, status_d;
  logic              found_q, found_d;
  logic              isprime_q, isprime_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CAND_W-1:0] prime1_q, prime1_d;
  logic [CAND_W-1:0] prime2_q, prime2_d;
  logic              cand_load, cand_step, cand_last;
  logic [CAND_W-1:0] cand;

  prime_candidate_gen u_cand (
    .clk    (clk),
    .reset  (reset),
    .load_i (cand_load),
    .seed_i (seed),
    .step_i (cand_step),
    .cand_o (cand),
    .last_o (cand_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      status_q  <= STATUS_OK;
      found_q   <= 1'b0;
      isprime_q <= 1'b0;
      tries_q   <= '0;
      tmo_q     <= '0;
      prime1_q  <= '0;
      prime2_q  <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      found_q   <= found_d;
      isprime_q <= isprime_d;
      tries_q   <= tries_d;
      tmo_q     <= tmo_d;
      prime1_q  <= prime1_d;
      prime2_q  <= prime2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    found_d   = found_q;
    isprime_d = isprime_q;
    tries_d   = tries_q;
    tmo_d     = tmo_q;
    prime1_d  = prime1_q;
    prime2_d  = prime2_q;
    cand_load = 1'b0;
    cand_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cand_load = 1'b1;
          found_d   = 1'b0;
          tries_d   = '0;
          prime1_d  = '0;
          prime2_d  = '0;
          status_d  = STATUS_OK;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tries_d = tries_q + TRY_W'(1);
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pc.pc_done) begin
          isprime_d = pc.pc_isprime;
          state_d   = S_EVAL;
        end else if (tmo_q == TMO_TERM) begin
          status_d = STATUS_TIMEOUT;
          state_d  = S_FAIL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_EVAL: begin
        if (isprime_q && found_q) begin
          prime2_d = cand;
          state_d  = S_DONE;
        end else begin
          if (isprime_q) begin
            prime1_d = cand;
            found_d  = 1'b1;
          end
          if (cand_last) begin
            status_d = STATUS_OVERFLOW;
            state_d  = S_FAIL;
          end else if (tries_q == TRY_LIMIT) begin
            status_d = STATUS_TRIES;
            state_d  = S_FAIL;
          end else begin
            cand_step = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pc.pc_candidate = cand;
  assign pc.pc_ready     = (state_q == S_ISSUE);
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_EVAL);
  assign done            = (state_q == S_DONE);
  assign fail            = (state_q == S_FAIL);
  assign status          = status_q;
  assign prime1          = prime1_q;
  assign prime2          = prime2_q;

endmodule
`default_nettype wire

// File: tb/tb_prime_pair_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prime_pair_search                                                 |
// | Scoreboard bench: two searchers (MAX_TRIES 1024 / 4, TIMEOUT 16).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_prime_pair_search;

  typedef struct packed {
    logic        f;
    logic [1:0]  st;
    logic [31:0] p1;
    logic [31:0] p2;
  } res_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        mute  = 1'b0;
  logic        start_r [2];
  logic [31:0] seed_r  [2];

  logic [31:0] p1_w   [2];
  logic [31:0] p2_w   [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        fail_w [2];
  logic [1:0]  st_w   [2];
  logic        rdy_w  [2];
  logic [31:0] cand_w [2];

  logic [31:0] cand_q [2][$];
  res_t        res_q  [2][$];
  int          res_cnt [2];
  int          n_ready [2];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  function automatic logic is_prime(input logic [31:0] n);
    logic [63:0] d;
    logic [63:0] nn;
    nn = {32'd0, n};
    if (n < 32'd2) return 1'b0;
    if (n[0] == 1'b0) return (n == 32'd2);
    for (d = 64'd3; d * d <= nn; d = d + 64'd2) begin
      if (nn % d == 64'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    prime_pair_search_if pif ();
    int unsigned cd   = 0;
    logic [31:0] held = '0;

    prime_pair_search #(
      .MAX_TRIES (gi == 0 ? 1024 : 4),
      .TIMEOUT   (16)
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start_r[gi]),
      .seed   (seed_r[gi]),
      .pc     (pif),
      .prime1 (p1_w[gi]),
      .prime2 (p2_w[gi]),
      .busy   (busy_w[gi]),
      .done   (done_w[gi]),
      .fail   (fail_w[gi]),
      .status (st_w[gi])
    );

    assign rdy_w[gi]  = pif.pc_ready;
    assign cand_w[gi] = pif.pc_candidate;

    // Behavioural checker: verdict 5 cycles after the issue strobe.
    always @(posedge clk) begin
      pif.pc_done    <= 1'b0;
      pif.pc_isprime <= 1'b0;
      if (pif.pc_ready && !(mute && gi == 0)) begin
        cd   <= 4;
        held <= pif.pc_candidate;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          pif.pc_done    <= 1'b1;
          pif.pc_isprime <= is_prime(held);
        end
      end
    end
  end

  task automatic monitor();
    logic [31:0] ec;
    res_t        er;
    res_t        ar;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          if (rdy_w[i]) begin
            n_ready[i]++;
            tests++;
            if (cand_q[i].size() == 0) begin
              fails++;
              $display("FAIL cand[%0d]: unexpected issue of %h, expected none", i, cand_w[i]);
            end else begin
              ec = cand_q[i].pop_front();
              if (cand_w[i] !== ec) begin
                fails++;
                $display("FAIL cand[%0d]: got %h, expected %h", i, cand_w[i], ec);
              end
            end
          end
          if (done_w[i] || fail_w[i]) begin
            res_cnt[i]++;
            tests++;
            ar = '{f: fail_w[i], st: st_w[i], p1: p1_w[i], p2: p2_w[i]};
            if (res_q[i].size() == 0) begin
              fails++;
              $display("FAIL result[%0d]: unexpected fail=%0b status=%0d p1=%h p2=%h, expected none",
                       i, ar.f, ar.st, ar.p1, ar.p2);
            end else begin
              er = res_q[i].pop_front();
              if (ar !== er || (done_w[i] && fail_w[i])) begin
                fails++;
                $display("FAIL result[%0d]: got fail=%0b status=%0d p1=%h p2=%h, expected fail=%0b status=%0d p1=%h p2=%h",
                         i, ar.f, ar.st, ar.p1, ar.p2, er.f, er.st, er.p1, er.p2);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic exp_c(input int i, input logic [31:0] c);
    cand_q[i].push_back(c);
  endtask

  task automatic exp_r(input int i, input logic f, input logic [1:0] st,
                       input logic [31:0] p1, input logic [31:0] p2);
    res_q[i].push_back('{f: f, st: st, p1: p1, p2: p2});
  endtask

  // Start from IDLE; one cycle later the search must be busy and issuing.
  task automatic kick(input int i, input logic [31:0] s);
    @(negedge clk);
    seed_r[i]  = s;
    start_r[i] = 1'b1;
    @(negedge clk);
    start_r[i] = 1'b0;
    tests++;
    if (!(busy_w[i] && rdy_w[i])) begin
      fails++;
      $display("FAIL start_latency[%0d]: busy=%0b pc_ready=%0b, expected 1/1", i, busy_w[i], rdy_w[i]);
    end
  endtask

  task automatic wait_res(input int i, input int target, input int budget);
    int n = 0;
    while (res_cnt[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (res_cnt[i] < target) begin
      fails++;
      $display("FAIL wait_result[%0d]: got %0d results, expected %0d", i, res_cnt[i], target);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input int i, input string tag);
    logic [101:0] v;
    v = {busy_w[i], done_w[i], fail_w[i], st_w[i], p1_w[i], p2_w[i], rdy_w[i], cand_w[i]};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL %s[%0d]: outputs busy=%0b done=%0b fail=%0b status=%0d p1=%h p2=%h rdy=%0b cand=%h, expected all 0",
               tag, i, busy_w[i], done_w[i], fail_w[i], st_w[i], p1_w[i], p2_w[i], rdy_w[i], cand_w[i]);
    end
  endtask

  initial begin
    int cyc;
    int nr;
    int rc;
    start_r = '{default: 1'b0};
    seed_r  = '{default: 32'd0};
    res_cnt = '{default: 0};
    n_ready = '{default: 0};
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero(0, "reset");
    check_zero(1, "reset");

    // Seed 40: 41 and 43 are both prime.
    exp_c(0, 32'd41); exp_c(0, 32'd43);
    exp_r(0, 1'b0, 2'd0, 32'd41, 32'd43);
    kick(0, 32'd40);
    wait_res(0, 1, 100);

    // Seed 0 is clamped up to 3.
    exp_c(0, 32'd3); exp_c(0, 32'd5);
    exp_r(0, 1'b0, 2'd0, 32'd3, 32'd5);
    kick(0, 32'd0);
    wait_res(0, 2, 100);

    // Seed 24: 25, 27 composite, then 29, 31.
    nr = n_ready[0];
    exp_c(0, 32'd25); exp_c(0, 32'd27); exp_c(0, 32'd29); exp_c(0, 32'd31);
    exp_r(0, 1'b0, 2'd0, 32'd29, 32'd31);
    kick(0, 32'd24);
    wait_res(0, 3, 150);
    tests++;
    if (n_ready[0] - nr != 4) begin
      fails++;
      $display("FAIL ready_count: got %0d pc_ready pulses, expected 4", n_ready[0] - nr);
    end

    // MAX_TRIES=4, seed 90: 97 found on the last allowed try.
    exp_c(1, 32'd91); exp_c(1, 32'd93); exp_c(1, 32'd95); exp_c(1, 32'd97);
    exp_r(1, 1'b1, 2'd1, 32'd97, 32'd0);
    kick(1, 32'd90);
    wait_res(1, 1, 150);

    // Top of the 32-bit range: overflow guard at 0xFFFFFFFF.
    exp_c(0, 32'hFFFF_FFF1); exp_c(0, 32'hFFFF_FFF3); exp_c(0, 32'hFFFF_FFF5);
    exp_c(0, 32'hFFFF_FFF7); exp_c(0, 32'hFFFF_FFF9); exp_c(0, 32'hFFFF_FFFB);
    exp_c(0, 32'hFFFF_FFFD); exp_c(0, 32'hFFFF_FFFF);
    exp_r(0, 1'b1, 2'd2, 32'hFFFF_FFFB, 32'd0);
    kick(0, 32'hFFFF_FFF1);
    wait_res(0, 4, 300);

    // Silent checker: timeout 16 cycles after pc_ready; a start in WAIT is ignored.
    mute = 1'b1;
    exp_c(0, 32'd41);
    exp_r(0, 1'b1, 2'd3, 32'd0, 32'd0);
    kick(0, 32'd40);
    cyc = 0;
    repeat (4) @(negedge clk);
    cyc += 4;
    seed_r[0]  = 32'd100;
    start_r[0] = 1'b1;
    @(negedge clk);
    cyc++;
    start_r[0] = 1'b0;
    while (!fail_w[0] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != 16) begin
      fails++;
      $display("FAIL timeout_latency: fail seen %0d cycles after pc_ready, expected 16", cyc);
    end
    repeat (3) @(negedge clk);
    mute = 1'b0;

    // Reset during WAIT, then the stale verdict arrives while idle.
    rc = res_cnt[0];
    exp_c(0, 32'd41);
    kick(0, 32'd40);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_zero(0, "abort");
    tests++;
    if (res_cnt[0] != rc) begin
      fails++;
      $display("FAIL abort_pulse: got %0d results after reset, expected %0d", res_cnt[0], rc);
    end

    exp_c(0, 32'd41); exp_c(0, 32'd43);
    exp_r(0, 1'b0, 2'd0, 32'd41, 32'd43);
    kick(0, 32'd40);
    wait_res(0, rc + 1, 100);

    for (int i = 0; i < 2; i++) begin
      tests++;
      if (cand_q[i].size() != 0 || res_q[i].size() != 0) begin
        fails++;
        $display("FAIL drain[%0d]: %0d candidates and %0d results left, expected 0/0",
                 i, cand_q[i].size(), res_q[i].size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
